// File: rtl/i2c_apb_sequencer.sv
// i2c_apb_sequencer
//   APB master that runs complete I2C transactions on the i2c_top register map.
//   The CPU posts one request (slave address, direction, byte count, prescale).
//   The sequencer then programs the controller, streams write bytes in, starts the
//   bus, polls STATUS and drains read bytes out. Afterwards it reports completion
//   with a one-cycle done pulse and an error code.
//
// Ports
//   pclk_i, preset_ni           clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake; ready is high only while idle
//   req_rw_i, req_saddr_i,      request fields: 1=read/0=write, 7-bit address,
//   req_len_i, req_psc_i        byte count (1..2**LEN_W-1), SCL prescale
//   wdata_valid_i/_ready_o/_i   write byte stream; ready marks the consuming cycle
//   rdata_valid_o, rdata_o      read byte stream; valid is a one-cycle pulse
//   done_o, err_o               end-of-transaction pulse; err 0 ok, 1 nack,
//                               2 poll timeout, 3 bad length (held until next request)
//   paddr_o..pready_i           APB master port towards i2c_top
module i2c_apb_sequencer #(
    parameter int unsigned LEN_W      = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'hC0,
    parameter int unsigned POLL_LIMIT = 4096
) (
    input  logic             pclk_i,
    input  logic             preset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rw_i,
    input  logic [6:0]       req_saddr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       req_psc_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [7:0]       wdata_i,
    output logic             rdata_valid_o,
    output logic [7:0]       rdata_o,
    output logic             done_o,
    output logic [1:0]       err_o,
    output logic [7:0]       paddr_o,
    output logic             psel_o,
    output logic             penable_o,
    output logic             pwrite_o,
    output logic [7:0]       pwdata_o,
    input  logic [7:0]       prdata_i,
    input  logic             pready_i
);

    localparam int unsigned   PW        = $clog2(POLL_LIMIT + 32'd1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 32'd1);
    localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_LEN  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CTRL, ST_SLV, ST_PSC, ST_WAIT_WD, ST_TXD, ST_PUSH, ST_CLR,
        ST_START, ST_POLL, ST_POP, ST_RXR, ST_RCLR, ST_STOP, ST_DONE
    } state_t;

    // Every state other than these three is exactly one APB transfer.
    function automatic logic is_apb(input state_t s);
        case (s)
            ST_IDLE, ST_WAIT_WD, ST_DONE: is_apb = 1'b0;
            default:                      is_apb = 1'b1;
        endcase
    endfunction

    function automatic logic is_read(input state_t s);
        case (s)
            ST_POLL, ST_RXR: is_read = 1'b1;
            default:         is_read = 1'b0;
        endcase
    endfunction

    // Register offset: TX=0 RX=1 STATUS=2 SLAVE=3 CMD=4 PSC=5.
    function automatic logic [2:0] reg_off(input state_t s);
        case (s)
            ST_TXD:  reg_off = 3'd0;
            ST_RXR:  reg_off = 3'd1;
            ST_POLL: reg_off = 3'd2;
            ST_SLV:  reg_off = 3'd3;
            ST_PSC:  reg_off = 3'd5;
            default: reg_off = 3'd4;
        endcase
    endfunction

    // CMD encoding: [7]rst_n [6]enable [5]rep_start [4]rw [3]tx_winc [2]tx_rinc
    // [1]rx_winc [0]rx_rinc. 0x80 keeps the core out of reset with enable off.
    function automatic logic [7:0] wr_data(input state_t s, input logic [7:0] wbyte,
                                           input logic [6:0] saddr, input logic rw,
                                           input logic [7:0] psc);
        case (s)
            ST_CTRL, ST_CLR, ST_RCLR, ST_STOP: wr_data = 8'h80;
            ST_SLV:   wr_data = {saddr, rw};
            ST_PSC:   wr_data = psc;
            ST_TXD:   wr_data = wbyte;
            ST_PUSH:  wr_data = 8'h88;
            ST_START: wr_data = {3'b110, rw, 4'b0000};
            ST_POP:   wr_data = 8'h81;
            default:  wr_data = 8'h00;
        endcase
    endfunction

    state_t           state_r, state_nxt_s;
    logic             phase_r, phase_nxt_s;       // 0 = SETUP, 1 = ACCESS
    logic [LEN_W-1:0] cnt_r, cnt_nxt_s;
    logic [PW-1:0]    poll_cnt_r, poll_nxt_s;
    logic [7:0]       wbyte_r, wbyte_nxt_s;
    logic [1:0]       err_pend_r, err_nxt_s;
    logic             rw_r;
    logic [6:0]       saddr_r;
    logic [7:0]       psc_r;
    logic             xfer_done_s, accept_s;

    logic             ready_r, rvalid_r, done_r, psel_r, penable_r, pwrite_r;
    logic [7:0]       rdata_r, paddr_r, pwdata_r;
    logic [1:0]       err_r;

    assign accept_s    = (state_r == ST_IDLE) && req_valid_i && ready_r;
    assign xfer_done_s = is_apb(state_r) && phase_r && pready_i;

    // Next-state, counters and APB phase sequencing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        poll_nxt_s  = poll_cnt_r;
        wbyte_nxt_s = wbyte_r;
        err_nxt_s   = err_pend_r;
        if (is_apb(state_r)) begin
            if (!phase_r) begin
                phase_nxt_s = 1'b1;
            end else if (pready_i) begin
                phase_nxt_s = 1'b0;
            end else begin
                phase_nxt_s = 1'b1;
            end
        end else begin
            phase_nxt_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_nxt_s = req_len_i;
                    if (req_len_i == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                        err_nxt_s   = ERR_LEN;
                    end else begin
                        state_nxt_s = ST_CTRL;
                        err_nxt_s   = ERR_OK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CTRL: state_nxt_s = xfer_done_s ? ST_SLV : state_r;
            ST_SLV:  state_nxt_s = xfer_done_s ? ST_PSC : state_r;
            ST_PSC: begin
                if (xfer_done_s) begin
                    state_nxt_s = rw_r ? ST_START : ST_WAIT_WD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT_WD: begin
                if (wdata_valid_i) begin
                    wbyte_nxt_s = wdata_i;
                    state_nxt_s = ST_TXD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_TXD:  state_nxt_s = xfer_done_s ? ST_PUSH : state_r;
            ST_PUSH: state_nxt_s = xfer_done_s ? ST_CLR : state_r;
            ST_CLR: begin
                if (xfer_done_s) begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = (cnt_r == CNT_ONE) ? ST_START : ST_WAIT_WD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_START: begin
                if (xfer_done_s) begin
                    poll_nxt_s  = {PW{1'b0}};
                    state_nxt_s = ST_POLL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_POLL: begin
                if (xfer_done_s) begin
                    if (poll_cnt_r != POLL_MAX) begin
                        poll_nxt_s = poll_cnt_r + {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        poll_nxt_s = poll_cnt_r;
                    end
                    // NACK wins even while busy is still reported.
                    if (prdata_i[1]) begin
                        state_nxt_s = ST_STOP;
                        err_nxt_s   = ERR_NACK;
                    end else if (!prdata_i[0]) begin
                        state_nxt_s = rw_r ? ST_POP : ST_STOP;
                    end else if (poll_cnt_r >= POLL_LAST) begin
                        state_nxt_s = ST_STOP;
                        err_nxt_s   = ERR_TMO;
                    end else begin
                        state_nxt_s = ST_POLL;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_POP:  state_nxt_s = xfer_done_s ? ST_RXR : state_r;
            ST_RXR:  state_nxt_s = xfer_done_s ? ST_RCLR : state_r;
            ST_RCLR: begin
                if (xfer_done_s) begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = (cnt_r == CNT_ONE) ? ST_STOP : ST_POP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_STOP: state_nxt_s = xfer_done_s ? ST_DONE : state_r;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and latched request fields.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_r    <= ST_IDLE;
            phase_r    <= 1'b0;
            cnt_r      <= {LEN_W{1'b0}};
            poll_cnt_r <= {PW{1'b0}};
            wbyte_r    <= 8'h00;
            err_pend_r <= 2'd0;
            rw_r       <= 1'b0;
            saddr_r    <= 7'h00;
            psc_r      <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            phase_r    <= phase_nxt_s;
            cnt_r      <= cnt_nxt_s;
            poll_cnt_r <= poll_nxt_s;
            wbyte_r    <= wbyte_nxt_s;
            err_pend_r <= err_nxt_s;
            if (accept_s) begin
                rw_r    <= req_rw_i;
                saddr_r <= req_saddr_i;
                psc_r   <= req_psc_i;
            end
        end
    end

    // Registered outputs, decoded from the upcoming state so they line up with it.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            ready_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 8'h00;
            done_r    <= 1'b0;
            err_r     <= 2'd0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= 8'h00;
            pwdata_r  <= 8'h00;
        end else begin
            ready_r   <= (state_nxt_s == ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            psel_r    <= is_apb(state_nxt_s);
            penable_r <= is_apb(state_nxt_s) && phase_nxt_s;
            pwrite_r  <= is_apb(state_nxt_s) && !is_read(state_nxt_s);
            paddr_r   <= is_apb(state_nxt_s) ? (BASE_ADDR | {5'b00000, reg_off(state_nxt_s)})
                                             : 8'h00;
            pwdata_r  <= wr_data(state_nxt_s, wbyte_nxt_s, saddr_r, rw_r, psc_r);
            rvalid_r  <= (state_r == ST_RXR) && xfer_done_s;
            if ((state_r == ST_RXR) && xfer_done_s) begin
                rdata_r <= prdata_i;
            end
            if (state_nxt_s == ST_DONE) begin
                err_r <= err_nxt_s;
            end else if (accept_s) begin
                err_r <= ERR_OK;
            end
        end
    end

    // The write-byte handshake must acknowledge in the same cycle it is offered.
    assign wdata_ready_o = (state_r == ST_WAIT_WD) && wdata_valid_i;

    assign req_ready_o   = ready_r;
    assign rdata_valid_o = rvalid_r;
    assign rdata_o       = rdata_r;
    assign done_o        = done_r;
    assign err_o         = err_r;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign pwrite_o      = pwrite_r;
    assign paddr_o       = paddr_r;
    assign pwdata_o      = pwdata_r;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Testbench for i2c_apb_sequencer: an APB slave model stands in for i2c_top and
// logs every completed transfer; a transaction-level reference model builds the
// expected APB log, read bytes and error code for each request.
module tb_i2c_apb_sequencer;

    localparam int LEN_W      = 4;
    localparam int POLL_LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [6:0] req_saddr = 7'h00;
    logic [3:0] req_len = 4'h0;
    logic [7:0] req_psc = 8'h00;
    logic       wdata_valid = 1'b0, wdata_ready;
    logic [7:0] wdata = 8'h00;
    logic       rdata_valid, done, psel, penable, pwrite, pready;
    logic [7:0] rdata, paddr, pwdata, prdata;
    logic [1:0] err;

    i2c_apb_sequencer #(.LEN_W(LEN_W), .BASE_ADDR(8'hC0), .POLL_LIMIT(POLL_LIMIT)) dut (
        .pclk_i(clk), .preset_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_saddr_i(req_saddr), .req_len_i(req_len), .req_psc_i(req_psc),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .err_o(err),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
    );

    always #5 clk = ~clk;

    // ---------------- APB slave model ----------------
    int         wait_n = 0;
    logic [7:0] status_seq [16];
    int         status_len = 1;
    logic [7:0] rx_bytes [16];
    logic [7:0] wbytes [16];
    int         st_idx = 0, rx_idx = 0, wcnt = 0;
    logic [7:0] setup_addr = 8'h00, setup_wdata = 8'h00;
    logic       setup_write = 1'b0;
    logic [17:0] log_q [$];   // {stable, write, addr, data}
    logic [3:0] st_sel;

    assign pready = (wait_n == 0) ? 1'b1 : (psel && penable && (wcnt == wait_n));
    assign st_sel = (st_idx < status_len) ? 4'(st_idx) : 4'(status_len - 1);

    always_comb begin
        prdata = 8'h00;
        if (paddr == 8'hC2) prdata = status_seq[st_sel];
        else if (paddr == 8'hC1) prdata = rx_bytes[4'(rx_idx)];
        else prdata = 8'h00;
    end

    always @(posedge clk) begin
        if (psel && !penable) begin
            setup_addr  <= paddr;
            setup_write <= pwrite;
            setup_wdata <= pwdata;
        end
        if (psel && penable) begin
            if (pready) begin
                wcnt <= 0;
                log_q.push_back({(setup_addr == paddr) && (setup_write == pwrite) &&
                                 (!pwrite || setup_wdata == pwdata),
                                 pwrite, paddr, pwrite ? pwdata : prdata});
                if (pwrite && paddr == 8'hC4 && (pwdata & 8'hC0) == 8'hC0) begin
                    st_idx <= 0;
                    rx_idx <= 0;
                end else if (!pwrite && paddr == 8'hC2) begin
                    st_idx <= st_idx + 1;
                end else if (!pwrite && paddr == 8'hC1) begin
                    rx_idx <= rx_idx + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [16:0] exp_log [$];
    logic [7:0]  exp_rd [$];
    logic [1:0]  exp_err;

    task automatic build_expect(input logic rw, input logic [6:0] sa, input int len,
                                input logic [7:0] psc);
        logic [7:0] v;
        bit settled;
        exp_log.delete();
        exp_rd.delete();
        if (len == 0) begin
            exp_err = 2'd3;
            return;
        end
        exp_err = 2'd0;
        exp_log.push_back({1'b1, 8'hC4, 8'h80});
        exp_log.push_back({1'b1, 8'hC3, sa, rw});
        exp_log.push_back({1'b1, 8'hC5, psc});
        if (!rw) begin
            for (int i = 0; i < len; i++) begin
                exp_log.push_back({1'b1, 8'hC0, wbytes[i]});
                exp_log.push_back({1'b1, 8'hC4, 8'h88});
                exp_log.push_back({1'b1, 8'hC4, 8'h80});
            end
        end
        exp_log.push_back({1'b1, 8'hC4, rw ? 8'hD0 : 8'hC0});
        settled = 1'b0;
        for (int i = 0; i < POLL_LIMIT && !settled; i++) begin
            v = status_seq[(i < status_len) ? i : status_len - 1];
            exp_log.push_back({1'b0, 8'hC2, v});
            if (v[1]) begin
                exp_err = 2'd1;
                settled = 1'b1;
            end else if (!v[0]) begin
                settled = 1'b1;
            end else if (i == POLL_LIMIT - 1) begin
                exp_err = 2'd2;
            end
        end
        if (exp_err == 2'd0 && rw) begin
            for (int i = 0; i < len; i++) begin
                exp_log.push_back({1'b1, 8'hC4, 8'h81});
                exp_log.push_back({1'b0, 8'hC1, rx_bytes[i]});
                exp_rd.push_back(rx_bytes[i]);
                exp_log.push_back({1'b1, 8'hC4, 8'h80});
            end
        end
        exp_log.push_back({1'b1, 8'hC4, 8'h80});
    endtask

    // ---------------- transaction driver ----------------
    task automatic run_txn(input logic rw, input logic [6:0] sa, input int len,
                           input logic [7:0] psc, input int stall);
        int base, cyc, widx, guard;
        bit got_done, psel_seen;
        logic [1:0] got_err;
        logic [7:0] rd_got [$];
        build_expect(rw, sa, len, psc);
        base = log_q.size();
        @(negedge clk);
        req_rw = rw; req_saddr = sa; req_len = 4'(len); req_psc = psc; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_done = 0; psel_seen = 0; got_err = 2'd0; cyc = 0; widx = 0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (psel) psel_seen = 1;
            if (rdata_valid) rd_got.push_back(rdata);
            if (done) begin
                got_done = 1;
                got_err = err;
            end
            if (stall > 0 && cyc == stall) begin
                check_eq("stall_psel", psel, 0);
                check_eq("stall_log", log_q.size() - base, 3);
            end
            wdata_valid = (!rw && widx < len && cyc >= stall && $urandom_range(2) != 0);
            wdata = wbytes[4'(widx)];
            #1;
            if (wdata_valid && wdata_ready) widx++;
        end
        wdata_valid = 1'b0;
        check_eq("done_seen", got_done, 1);
        check_eq("err", got_err, exp_err);
        if (len == 0) begin
            check_eq("len0_latency", cyc, 1);
            check_eq("len0_no_psel", psel_seen, 0);
        end
        check_eq("wbytes_used", widx, rw ? 0 : len);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("ready_back", req_ready, 1);
        check_eq("err_hold", err, exp_err);
        check_eq("apb_count", log_q.size() - base, exp_log.size());
        for (int i = 0; i < exp_log.size() && base + i < log_q.size(); i++)
            check_eq("apb_xfer", log_q[base + i], {1'b1, exp_log[i]});
        check_eq("rd_count", rd_got.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++)
            check_eq("rdata", rd_got[i], exp_rd[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard, k;
        bit saw_done;
        for (int i = 0; i < 16; i++) begin
            status_seq[i] = 8'h00; rx_bytes[i] = 8'h00; wbytes[i] = 8'h00;
        end
        // Reset state
        #1;
        check_eq("reset_outs", {req_ready, wdata_ready, rdata_valid, rdata, done, err,
                               paddr, psel, penable, pwrite, pwdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", req_ready, 1);

        // Write 3 bytes, STATUS busy for 5 polls, stalled write stream at start
        wbytes[0] = 8'h0B; wbytes[1] = 8'h0C; wbytes[2] = 8'h0D;
        for (int i = 0; i < 5; i++) status_seq[i] = 8'h01;
        status_seq[5] = 8'h00; status_len = 6;
        run_txn(1'b0, 7'h61, 3, 8'h08, 30);

        // Read 2 bytes
        rx_bytes[0] = 8'hA5; rx_bytes[1] = 8'h5A;
        status_seq[0] = 8'h00; status_len = 1;
        run_txn(1'b1, 7'h62, 2, 8'h08, 0);

        // NACK on first poll
        status_seq[0] = 8'h03; status_len = 1;
        run_txn(1'b1, 7'h62, 2, 8'h04, 0);

        // Poll timeout
        status_seq[0] = 8'h01; status_len = 1;
        run_txn(1'b0, 7'h10, 1, 8'h02, 0);

        // Bad length
        run_txn(1'b0, 7'h11, 0, 8'h02, 0);

        // Wait-state extension
        wait_n = 3;
        status_seq[0] = 8'h01; status_seq[1] = 8'h00; status_len = 2;
        wbytes[0] = 8'h3C; wbytes[1] = 8'hC3;
        run_txn(1'b0, 7'h2A, 2, 8'h20, 0);

        // Reset in the middle of a TX transfer
        @(negedge clk);
        req_rw = 1'b0; req_saddr = 7'h33; req_len = 4'd2; req_psc = 8'h10; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0; wdata = 8'h11; wdata_valid = 1'b1;
        guard = 0;
        while (!(psel && penable && paddr == 8'hC0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_txd", psel && penable && paddr == 8'hC0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outs", {req_ready, wdata_ready, rdata_valid, rdata, done, err,
                                paddr, psel, penable, pwrite, pwdata}, 0);
        wdata_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        @(negedge clk);
        check_eq("midrst_ready", req_ready, 1);
        check_eq("midrst_psel", psel, 0);
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check_eq("midrst_no_done", saw_done, 0);

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            wait_n = $urandom_range(2);
            k = $urandom_range(9);
            for (int i = 0; i < k; i++) status_seq[i] = ($urandom_range(5) == 0) ? 8'h03 : 8'h01;
            status_seq[k] = ($urandom_range(3) == 0) ? 8'h02 : 8'h00;
            status_len = k + 1;
            for (int i = 0; i < 16; i++) begin
                wbytes[i] = 8'($urandom);
                rx_bytes[i] = 8'($urandom);
            end
            run_txn(1'($urandom), 7'($urandom), $urandom_range(15), 8'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
